// File: rtl/fifo_ptr_ctrl.sv
// rtl/fifo_ptr_ctrl.sv - pointer/occupancy/status controller for a 2**ADDR_W entry FIFO memory
// Build option FIFO_CTRL_STICKY_ERR_EN: overflow/underflow held until err_clr instead of pulsing.
module fifo_ptr_ctrl #(
  parameter int ADDR_W = 4,
  parameter int THRESH = 12
) (
  input  logic              wclk,
  input  logic              rst,
  input  logic              push,
  input  logic              pop,
  input  logic              err_clr,
  output logic              wen,
  output logic [ADDR_W-1:0] waddr,
  output logic [ADDR_W-1:0] raddr,
  output logic [ADDR_W:0]   count,
  output logic              full,
  output logic              empty,
  output logic              threshold,
  output logic              overflow,
  output logic              underflow
);

  localparam int              DEPTH    = 2 ** ADDR_W;
  localparam logic [ADDR_W:0] DEPTH_C  = (ADDR_W + 1)'(DEPTH);
  localparam logic [ADDR_W:0] THRESH_C = (ADDR_W + 1)'(THRESH);
  localparam logic [ADDR_W:0] CNT_ONE  = (ADDR_W + 1)'(1);
  localparam logic [ADDR_W-1:0] PTR_ONE = ADDR_W'(1);

  logic [ADDR_W-1:0] waddr_q, waddr_d;
  logic [ADDR_W-1:0] raddr_q, raddr_d;
  logic [ADDR_W:0]   count_q, count_d;
  logic              ovf_q, ovf_d;
  logic              unf_q, unf_d;
  logic              pop_acc, push_acc;
  logic              ovf_evt, unf_evt;

  assign full      = (count_q == DEPTH_C);
  assign empty     = (count_q == '0);
  assign threshold = (count_q >= THRESH_C);

  // A pop frees a slot in the same edge, so a full FIFO can still take a push.
  assign pop_acc  = pop & ~empty;
  assign push_acc = push & (~full | pop_acc);
  assign ovf_evt  = push & full & ~pop_acc;
  assign unf_evt  = pop & empty;

  always_comb begin
    waddr_d = push_acc ? waddr_q + PTR_ONE : waddr_q;
    raddr_d = pop_acc ? raddr_q + PTR_ONE : raddr_q;
    count_d = count_q;
    if (push_acc && !pop_acc) begin
      count_d = count_q + CNT_ONE;
    end else if (pop_acc && !push_acc) begin
      count_d = count_q - CNT_ONE;
    end
  end

`ifdef FIFO_CTRL_STICKY_ERR_EN
  // A fresh event outranks err_clr arriving on the same edge.
  always_comb begin
    ovf_d = ovf_evt | (ovf_q & ~err_clr);
    unf_d = unf_evt | (unf_q & ~err_clr);
  end
`else
  logic unused_err_clr;
  assign unused_err_clr = err_clr;

  always_comb begin
    ovf_d = ovf_evt;
    unf_d = unf_evt;
  end
`endif

  always_ff @(posedge wclk) begin
    if (rst) begin
      waddr_q <= '0;
      raddr_q <= '0;
      count_q <= '0;
      ovf_q   <= 1'b0;
      unf_q   <= 1'b0;
    end else begin
      waddr_q <= waddr_d;
      raddr_q <= raddr_d;
      count_q <= count_d;
      ovf_q   <= ovf_d;
      unf_q   <= unf_d;
    end
  end

  assign wen       = push_acc;
  assign waddr     = waddr_q;
  assign raddr     = raddr_q;
  assign count     = count_q;
  assign overflow  = ovf_q;
  assign underflow = unf_q;

endmodule

// File: tb/tb_fifo_ptr_ctrl.sv
// tb/tb_fifo_ptr_ctrl.sv - directed and model-checked bench for fifo_ptr_ctrl
module tb_fifo_ptr_ctrl;

  logic       clk = 1'b0;
  logic       rst, push, pop, err_clr;
  logic       wen, full, empty, threshold, overflow, underflow;
  logic [3:0] waddr, raddr;
  logic [4:0] count;

  int n_cmp = 0;
  int n_err = 0;

  fifo_ptr_ctrl #(.ADDR_W(4), .THRESH(12)) dut (
    .wclk(clk), .rst(rst), .push(push), .pop(pop), .err_clr(err_clr),
    .wen(wen), .waddr(waddr), .raddr(raddr), .count(count),
    .full(full), .empty(empty), .threshold(threshold),
    .overflow(overflow), .underflow(underflow)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Inputs change just after the falling edge; combinational outputs settle by #1.
  task automatic drive(input logic p, input logic q);
    push = p;
    pop  = q;
    #1;
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  int  m_cnt, m_w, m_r;
  logic m_ovf, m_unf, p_r, q_r, pa, qa, oe, ue;

  initial begin
    rst = 1'b1; push = 1'b1; pop = 1'b1; err_clr = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    drive(0, 0);
    check("rst_waddr", waddr, 0);
    check("rst_raddr", raddr, 0);
    check("rst_count", count, 0);
    check("rst_empty", empty, 1);
    check("rst_full", full, 0);
    check("rst_thresh", threshold, 0);
    check("rst_ovf", overflow, 0);
    check("rst_unf", underflow, 0);
    check("rst_wen", wen, 0);

    for (int i = 0; i < 16; i++) begin
      drive(1, 0);
      check("fill_wen", wen, 1);
      check("fill_waddr", waddr, i);
      tick();
      check("fill_count", count, i + 1);
      check("fill_thresh", threshold, (i + 1 >= 12) ? 1 : 0);
    end
    check("fill_wrap", waddr, 0);
    check("fill_full", full, 1);

    drive(1, 0);
    check("ovf_wen", wen, 0);
    tick();
    check("ovf_waddr", waddr, 0);
    check("ovf_count", count, 16);
    check("ovf_flag", overflow, 1);
    drive(0, 0);
    tick();
`ifdef FIFO_CTRL_STICKY_ERR_EN
    check("ovf_held", overflow, 1);
    err_clr = 1'b1;
    tick();
    err_clr = 1'b0;
    check("ovf_clr", overflow, 0);
`else
    check("ovf_pulse", overflow, 0);
`endif

    drive(1, 1);
    check("fpp_wen", wen, 1);
    tick();
    check("fpp_waddr", waddr, 1);
    check("fpp_raddr", raddr, 1);
    check("fpp_count", count, 16);
    check("fpp_ovf", overflow, 0);

    for (int i = 0; i < 16; i++) begin
      drive(0, 1);
      tick();
      check("drain_raddr", raddr, (i + 2) % 16);
      check("drain_count", count, 15 - i);
    end
    check("drain_empty", empty, 1);
    drive(0, 1);
    tick();
    check("unf_raddr", raddr, 1);
    check("unf_count", count, 0);
    check("unf_flag", underflow, 1);
    drive(1, 1);
    check("epp_wen", wen, 1);
    tick();
    check("epp_count", count, 1);
    check("epp_unf", underflow, 1);
    check("epp_waddr", waddr, 2);
    check("epp_raddr", raddr, 1);
    err_clr = 1'b1;
    drive(0, 0);
    tick();
    err_clr = 1'b0;

    for (int i = 0; i < 6; i++) begin
      drive(1, 0);
      tick();
    end
    check("mid_count7", count, 7);
    rst = 1'b1;
    drive(1, 1);
    tick();
    rst = 1'b0;
    drive(0, 0);
    check("mrst_count", count, 0);
    check("mrst_waddr", waddr, 0);
    check("mrst_raddr", raddr, 0);
    check("mrst_ovf", overflow, 0);
    check("mrst_unf", underflow, 0);
    check("mrst_empty", empty, 1);

    m_cnt = 0; m_w = 0; m_r = 0; m_ovf = 1'b0; m_unf = 1'b0;
    for (int i = 0; i < 400; i++) begin
      if ((i / 50) % 2 == 0) begin
        p_r = ($urandom_range(0, 3) != 0);
        q_r = ($urandom_range(0, 3) == 0);
      end else begin
        p_r = ($urandom_range(0, 3) == 0);
        q_r = ($urandom_range(0, 3) != 0);
      end
      qa = q_r && (m_cnt != 0);
      pa = p_r && ((m_cnt != 16) || qa);
      oe = p_r && (m_cnt == 16) && !qa;
      ue = q_r && (m_cnt == 0);
      drive(p_r, q_r);
      check("rnd_wen", wen, pa);
      tick();
      m_cnt = m_cnt + (pa ? 1 : 0) - (qa ? 1 : 0);
      if (pa) m_w = (m_w + 1) % 16;
      if (qa) m_r = (m_r + 1) % 16;
`ifdef FIFO_CTRL_STICKY_ERR_EN
      m_ovf = m_ovf | oe;
      m_unf = m_unf | ue;
`else
      m_ovf = oe;
      m_unf = ue;
`endif
      check("rnd_count", count, m_cnt);
      check("rnd_waddr", waddr, m_w);
      check("rnd_raddr", raddr, m_r);
      check("rnd_full", full, (m_cnt == 16) ? 1 : 0);
      check("rnd_empty", empty, (m_cnt == 0) ? 1 : 0);
      check("rnd_thresh", threshold, (m_cnt >= 12) ? 1 : 0);
      check("rnd_ovf", overflow, m_ovf);
      check("rnd_unf", underflow, m_unf);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
